multi_event_counter: RTL
========================

MULTI_EVENT_COUNTER -- requirements
Module: multi_event_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent counter channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 64: bit width of each channel counter.
REQ-003 SHALL have parameter PRESC_W, default 2: bit width of each channel's prescale divider.
REQ-004 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port En  input  1  count enable for the selected channel.
REQ-007 SHALL have port Sel  input  SEL_W=max(1,clog2(NUM_CH))  channel select for En, Clr and Div_we.
REQ-008 SHALL have port Clr  input  1  clears the selected channel's counter, prescaler and overflow flag.
REQ-009 SHALL have port Div_we  input  1  write strobe for the selected channel's divide value.
REQ-010 SHALL have port Div  input  PRESC_W  divide value written on Div_we.
REQ-011 SHALL have port Count  output  NUM_CH*WIDTH  flattened counters; channel i at bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port Ovf  output  NUM_CH  sticky per-channel overflow flags.
REQ-013 SHALL have port Tick  output  NUM_CH  one-cycle pulse per channel, high in the cycle following an increment.

Function
REQ-014 SHALL act only on channel i = Sel; all other channels hold state, and their Tick outputs are 0.
REQ-015 SHALL, on an enabled cycle (En=1, no Clr, no Div_we), set presc_i to 0 and increment count_i by 1 if presc_i == div_i, else increment presc_i.
REQ-016 SHALL therefore increment on every enabled cycle when div_i=0, and on every (div_i+1)-th enabled cycle otherwise; the first increment after reset falls on enabled cycle div_i+1.
REQ-017 SHALL assert Tick[i] for exactly one cycle, registered together with the count_i update.
REQ-018 SHALL, on an increment from all-ones, set Ovf[i]=1; Ovf stays set until Clr of that channel or Reset.
REQ-019 SHALL, on Clr=1, zero count_i, presc_i, Ovf[i] and Tick[i] of the selected channel; Clr has priority over En and Div_we.
REQ-020 SHALL, on Div_we=1 without Clr, load div_i from Div, zero presc_i and suppress any increment that cycle.
REQ-021 SHALL ignore En, Clr and Div_we when Sel >= NUM_CH.
REQ-022 SHALL present Count and Ovf directly from registers (no combinational path from inputs).

Reset
REQ-023 SHALL, with Reset=1 at a Clk edge, set every count, presc, div, Ovf and Tick to 0; Reset overrides all other inputs, including mid-prescale.

Configuration
REQ-024 SHALL, with macro MULTI_EVENT_COUNTER_SAT_EN defined, saturate a counter at all-ones: further increments hold the value, set Ovf[i] and still pulse Tick[i].
REQ-025 SHALL, without MULTI_EVENT_COUNTER_SAT_EN, wrap a counter from all-ones to 0 on increment, set Ovf[i] and pulse Tick[i].

Structure
REQ-026 SHALL place the default constants (NUM_CH, WIDTH, PRESC_W) and the SEL_W computation in package multi_event_counter_pkg.
REQ-027 SHALL implement one channel (counter, prescaler, divide register, Ovf, Tick) as sub-module event_counter_channel, instantiated NUM_CH times by a generate loop.

Verification
REQ-028 SHALL cover: Reset, then Sel=0 with Div=0 and 10 cycles of En=1 -> Count ch0 = 10, Tick[0] high for 10 cycles, other channels 0.
REQ-029 SHALL cover: Div_we with Sel=1 and Div=3, then 8 cycles of En=1 -> Count ch1 = 2, Tick[1] pulses after the 4th and 8th enables.
REQ-030 SHALL cover: WIDTH=8, ch2 counter at 0xFF, one increment -> 0x00 without SAT_EN and 0xFF with SAT_EN; Ovf[2]=1 in both builds.
REQ-031 SHALL cover: Clr and En on the same cycle for ch0, with count 5 -> count 0, Ovf[0]=0, no Tick.
REQ-032 SHALL cover: Reset asserted after 2 of 4 prescale steps on ch1 -> all state 0; the next 4 enables give exactly 1 increment once div is rewritten to 3.
REQ-033 SHALL cover: NUM_CH=3, Sel=3 with En=1 -> no channel changes.

Source files
------------

// File: rtl/multi_event_counter_pkg.sv
// Shared defaults and select-width helper for the multi-channel event counter.
package multi_event_counter_pkg;

  localparam int unsigned NUM_CH_DEF  = 4;
  localparam int unsigned WIDTH_DEF   = 64;
  localparam int unsigned PRESC_W_DEF = 2;

  function automatic int unsigned sel_width(input int unsigned num_ch);
    return (num_ch > 1) ? int'($clog2(num_ch)) : 1;
  endfunction

endpackage

// File: rtl/event_counter_channel.sv
// One counter channel: prescaler, divide register, counter, sticky overflow and tick.
// MULTI_EVENT_COUNTER_SAT_EN selects saturation instead of wrap at all-ones.
module event_counter_channel #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned PRESC_W = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               sel,
  input  logic               en,
  input  logic               clr,
  input  logic               div_we,
  input  logic [PRESC_W-1:0] div,
  output logic [WIDTH-1:0]   count,
  output logic               ovf,
  output logic               tick
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] div_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
      presc <= '0;
      div_q <= '0;
      ovf   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sel) begin
        // Clr beats Div_we, which beats En
        if (clr) begin
          count <= '0;
          presc <= '0;
          ovf   <= 1'b0;
        end else if (div_we) begin
          div_q <= div;
          presc <= '0;
        end else if (en) begin
          if (presc == div_q) begin
            presc <= '0;
            tick  <= 1'b1;
            if (count == '1) begin
              ovf <= 1'b1;
`ifdef MULTI_EVENT_COUNTER_SAT_EN
              count <= count;
`else
              count <= '0;
`endif
            end else begin
              count <= count + WIDTH'(1);
            end
          end else begin
            presc <= presc + PRESC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_event_counter.sv
// Bank of NUM_CH independent prescaled event counters sharing one select/control port.
// Define MULTI_EVENT_COUNTER_SAT_EN for saturating counters (default: wrap).
module multi_event_counter
  import multi_event_counter_pkg::*;
#(
  parameter  int unsigned NUM_CH  = NUM_CH_DEF,
  parameter  int unsigned WIDTH   = WIDTH_DEF,
  parameter  int unsigned PRESC_W = PRESC_W_DEF,
  localparam int unsigned SEL_W   = sel_width(NUM_CH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    En,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    Clr,
  input  logic                    Div_we,
  input  logic [PRESC_W-1:0]      Div,
  output logic [NUM_CH*WIDTH-1:0] Count,
  output logic [NUM_CH-1:0]       Ovf,
  output logic [NUM_CH-1:0]       Tick
);

  // Out-of-range Sel matches no channel, so it is ignored naturally
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = (Sel == SEL_W'(i));

    event_counter_channel #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .Clk    (Clk),
      .Reset  (Reset),
      .sel    (hit),
      .en     (En),
      .clr    (Clr),
      .div_we (Div_we),
      .div    (Div),
      .count  (Count[i*WIDTH +: WIDTH]),
      .ovf    (Ovf[i]),
      .tick   (Tick[i])
    );
  end

endmodule
